// File: rtl/axis_img_sender_if.sv
// AXI4-Stream pair for the image sender: image words out (m_axis_*), prediction word back (s_axis_*).
interface axis_img_sender_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_axis_valid;
  logic [DATA_WIDTH-1:0] m_axis_data;
  logic                  m_axis_last;
  logic                  m_axis_ready;
  logic                  s_axis_valid;
  logic [DATA_WIDTH-1:0] s_axis_data;
  logic                  s_axis_last;
  logic                  s_axis_ready;

  modport master (
    output m_axis_valid, m_axis_data, m_axis_last,
    input  m_axis_ready,
    input  s_axis_valid, s_axis_data, s_axis_last,
    output s_axis_ready
  );

  modport slave (
    input  m_axis_valid, m_axis_data, m_axis_last,
    output m_axis_ready,
    output s_axis_valid, s_axis_data, s_axis_last,
    input  s_axis_ready
  );
endinterface

// File: rtl/axis_img_sender.sv
// Snapshots a flat image, streams it as N AXIS words (TLAST on the final one),
// then collects one prediction word with an optional watchdog.
module axis_img_sender #(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_INPUT_WORDS = 32,
  parameter int TIMEOUT_CYCLES        = 65535
) (
  input  logic                                        axi_clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [DATA_WIDTH*NUMBER_OF_INPUT_WORDS-1:0] img_in,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        error,
  output logic [DATA_WIDTH-1:0]                       result,
  axis_img_sender_if.master                           axis
);
  localparam int N  = NUMBER_OF_INPUT_WORDS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t                       state, state_nxt;
  logic [N-1:0][DATA_WIDTH-1:0] shadow;
  logic [CW-1:0]                word_cnt;
  logic [31:0]                  timeout_cnt;
  logic                         tx_hs, rx_hs, to_hit;

  assign tx_hs  = (state == S_SEND) && axis.m_axis_ready;
  assign rx_hs  = (state == S_WAIT) && axis.s_axis_valid;
  assign to_hit = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) && (timeout_cnt == TO_LAST);

  always_ff @(posedge axi_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SEND;
      S_SEND:  if (tx_hs && (word_cnt == LAST_IDX)) state_nxt = S_WAIT;
      S_WAIT:  if (rx_hs || to_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      shadow      <= '0;
      word_cnt    <= '0;
      timeout_cnt <= '0;
      result      <= '0;
      error       <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        shadow      <= img_in;
        word_cnt    <= '0;
        timeout_cnt <= '0;
      end
      if (tx_hs && (word_cnt != LAST_IDX)) word_cnt <= word_cnt + 1'b1;
      if (state == S_WAIT) timeout_cnt <= timeout_cnt + 32'd1;
      // A handshake landing on the timeout cycle still counts as a good result.
      if (rx_hs) begin
        result <= axis.s_axis_data;
        error  <= ~axis.s_axis_last;
      end else if (to_hit) begin
        error  <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only; ready inputs never reach an output.
  assign busy              = (state != S_IDLE);
  assign done              = (state == S_DONE);
  assign axis.m_axis_valid = (state == S_SEND);
  assign axis.m_axis_data  = (state == S_SEND) ? shadow[word_cnt] : '0;
  assign axis.m_axis_last  = (state == S_SEND) && (word_cnt == LAST_IDX);
  assign axis.s_axis_ready = (state == S_WAIT);
endmodule

// File: tb/tb_axis_img_sender.sv
// Directed-random bench for axis_img_sender: frame content, handshake timing, result/timeout rules.
module tb_axis_img_sender;
  localparam int DW = 32;
  localparam int N  = 32;
  localparam int TO = 16;

  logic            axi_clk = 1'b0;
  logic            rst     = 1'b1;
  logic            start   = 1'b0;
  logic [DW*N-1:0] img_in  = '0;
  logic            busy, done, error;
  logic [DW-1:0]   result;

  axis_img_sender_if #(.DATA_WIDTH(DW)) axis ();

  axis_img_sender #(
    .DATA_WIDTH(DW), .NUMBER_OF_INPUT_WORDS(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .axi_clk(axi_clk), .rst(rst), .start(start), .img_in(img_in),
    .busy(busy), .done(done), .error(error), .result(result), .axis(axis)
  );

  always #5 axi_clk = ~axi_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Passive monitor: every accepted beat as {last,data}, plus stability violations.
  logic [DW:0] mon_q[$];
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_beat = '0;
  always @(negedge axi_clk) begin
    if (prev_stall && !rst &&
        (!axis.m_axis_valid || ({axis.m_axis_last, axis.m_axis_data} !== prev_beat)))
      stab_err++;
    prev_stall = axis.m_axis_valid && !axis.m_axis_ready;
    prev_beat  = {axis.m_axis_last, axis.m_axis_data};
    if (axis.m_axis_valid && axis.m_axis_ready)
      mon_q.push_back({axis.m_axis_last, axis.m_axis_data});
  end

  // Reference state: snapshot words of the current frame and the last reported result.
  logic [DW-1:0] exp_w[N];
  logic [DW-1:0] model_result = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
    cyc++;
  endtask

  // resp_at: -2 = valid held from start, -1 = silent, k>=0 = one-cycle pulse k cycles into the wait.
  task automatic run_frame(input string tag, input bit rnd_ready, input int resp_at,
                           input logic [DW-1:0] rdata, input logic rlast, input bit disturb);
    int base, wait_cyc, done_cyc, lat;
    logic [DW-1:0] res, exp_res;
    logic err, exp_err;
    base = mon_q.size();
    wait_cyc = -1; done_cyc = -1; res = '0; err = 1'b0;
    for (int j = 0; j < N; j++) img_in[DW*j +: DW] = exp_w[j];
    axis.s_axis_data = rdata;
    axis.s_axis_last = rlast;
    axis.s_axis_valid = (resp_at == -2);
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    if (disturb) for (int j = 0; j < N; j++) img_in[DW*j +: DW] = $urandom;
    while (cyc < 600) begin
      if (axis.s_axis_ready && wait_cyc < 0) wait_cyc = cyc;
      if (done) begin
        done_cyc = cyc; res = result; err = error;
        break;
      end
      axis.m_axis_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (resp_at >= 0) axis.s_axis_valid = (wait_cyc >= 0) && (cyc - wait_cyc == resp_at);
      if (disturb) start = (cyc == 5);
      tick();
    end
    start = 1'b0; axis.s_axis_valid = 1'b0; axis.m_axis_ready = 1'b0;

    if (resp_at == -1) begin
      exp_res = model_result; exp_err = 1'b1; lat = TO;
    end else begin
      exp_res = rdata; exp_err = !rlast; lat = (resp_at < 0 ? 0 : resp_at) + 1;
    end
    model_result = exp_res;

    check({tag, "_done_seen"}, done_cyc >= 0, 1);
    check({tag, "_nwords"}, mon_q.size() - base, N);
    for (int j = 0; j < N; j++)
      if (base + j < mon_q.size())
        check($sformatf("%s_w%0d", tag, j), mon_q[base + j], {(j == N - 1), exp_w[j]});
    check({tag, "_wait_cyc"}, wait_cyc, (rnd_ready ? wait_cyc : N + 1));
    check({tag, "_done_lat"}, done_cyc - wait_cyc, lat);
    check({tag, "_result"}, res, exp_res);
    check({tag, "_error"}, err, exp_err);
    tick();
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int base, s0;
    axis.m_axis_ready = 1'b0;
    axis.s_axis_valid = 1'b0;
    axis.s_axis_data  = '0;
    axis.s_axis_last  = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_result", result, 0);
    check("rst_mvalid", axis.m_axis_valid, 0);
    check("rst_mlast", axis.m_axis_last, 0);
    check("rst_mdata", axis.m_axis_data, 0);
    check("rst_sready", axis.s_axis_ready, 0);

    // Basic frame, zero-latency responder with valid already up.
    for (int j = 0; j < N; j++) exp_w[j] = 32'h100 + j;
    s0 = stab_err;
    run_frame("basic", 1'b0, -2, 32'h7, 1'b1, 1'b0);

    // Random backpressure; stall cycles must hold data/last.
    for (int j = 0; j < N; j++) exp_w[j] = $urandom;
    run_frame("bp", 1'b1, 2, $urandom, 1'b1, 1'b0);
    check("bp_stable", stab_err - s0, 0);

    // Result without TLAST.
    for (int j = 0; j < N; j++) exp_w[j] = $urandom;
    run_frame("malformed", 1'b0, 0, 32'h3, 1'b0, 1'b0);

    // Silent responder: watchdog fires, result keeps 0x3.
    for (int j = 0; j < N; j++) exp_w[j] = $urandom;
    run_frame("timeout", 1'b1, -1, 32'hdead, 1'b1, 1'b0);

    // Handshake exactly on the watchdog cycle wins.
    for (int j = 0; j < N; j++) exp_w[j] = $urandom;
    run_frame("to_edge", 1'b0, TO - 1, $urandom, 1'b1, 1'b0);

    // Second start mid-SEND and img_in scribbled after start.
    for (int j = 0; j < N; j++) exp_w[j] = $urandom;
    run_frame("snapshot", 1'b1, 3, $urandom, 1'b1, 1'b1);

    // Reset after ten words: frame abandoned, next frame starts from word 0.
    for (int j = 0; j < N; j++) img_in[DW*j +: DW] = $urandom;
    base = mon_q.size();
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    axis.m_axis_ready = 1'b1;
    while (mon_q.size() - base < 10 && cyc < 100) tick();
    check("midrst_sent10", mon_q.size() - base, 10);
    axis.m_axis_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_mvalid", axis.m_axis_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_done", done, 0);
    check("midrst_sready", axis.s_axis_ready, 0);
    rst = 1'b0;
    model_result = '0;
    tick();
    check("midrst_no_done", done, 0);
    for (int j = 0; j < N; j++) exp_w[j] = $urandom;
    run_frame("fresh", 1'b0, 1, $urandom, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
